// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: converts a requested Q value into one-cycle J/K
// excitation for a bank of negative-edge JK flip-flops. After each drive pass
// it compares the flip-flop feedback with the target. A mismatch triggers
// another pass, up to a bounded number of retries.
module jk_excitation_driver #(
   parameter int WIDTH       = 4,
   parameter int TOGGLE_MODE = 0,
   parameter int MAX_RETRY   = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [7:0]       err_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_tgt_q;
   logic [WIDTH-1:0] w_tgt_next;
   logic [WIDTH-1:0] r_j;
   logic [WIDTH-1:0] r_k;
   logic [WIDTH-1:0] w_j_next;
   logic [WIDTH-1:0] w_k_next;
   logic [2:0]       r_retry;
   logic [2:0]       w_retry_next;
   logic             r_done;
   logic             r_err;
   logic             w_done_next;
   logic             w_err_next;
   logic [7:0]       r_err_count;
   logic [7:0]       w_err_count_next;

   // Excitation always moves the flip-flops from the current feedback toward
   // the active target. In IDLE that target is the incoming request. After
   // acceptance it is the latched copy.
   logic [WIDTH-1:0] w_exc_tgt;
   logic [WIDTH-1:0] w_exc_j;
   logic [WIDTH-1:0] w_exc_k;

   assign w_exc_tgt = (r_state == ST_IDLE) ? tgt_data : r_tgt_q;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_exc
         if (TOGGLE_MODE != 0) begin : g_toggle
            assign w_exc_j[gi] = q_fb[gi] ^ w_exc_tgt[gi];
            assign w_exc_k[gi] = q_fb[gi] ^ w_exc_tgt[gi];
         end else begin : g_setreset
            assign w_exc_j[gi] = ~q_fb[gi] & w_exc_tgt[gi];
            assign w_exc_k[gi] = q_fb[gi] & ~w_exc_tgt[gi];
         end
      end
   endgenerate

   // Next-state logic. J/K default to zero, so excitation is only ever
   // presented for the single cycle spent in DRIVE.
   always_comb begin
      w_state_next     = r_state;
      w_tgt_next       = r_tgt_q;
      w_retry_next     = r_retry;
      w_j_next         = '0;
      w_k_next         = '0;
      w_done_next      = 1'b0;
      w_err_next       = 1'b0;
      w_err_count_next = r_err_count;
      case (r_state)
         ST_IDLE: begin
            if (tgt_valid) begin
               w_tgt_next   = tgt_data;
               w_retry_next = '0;
               w_j_next     = w_exc_j;
               w_k_next     = w_exc_k;
               w_state_next = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            w_state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (q_fb == r_tgt_q) begin
               w_done_next  = 1'b1;
               w_state_next = ST_IDLE;
            end else if (r_retry < 3'(MAX_RETRY)) begin
               w_retry_next = r_retry + 3'd1;
               w_j_next     = w_exc_j;
               w_k_next     = w_exc_k;
               w_state_next = ST_DRIVE;
            end else begin
               w_err_next   = 1'b1;
               if (r_err_count != 8'hFF) begin
                  w_err_count_next = r_err_count + 8'd1;
               end
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State register. Reset clears the excitation immediately, so a reset
   // during DRIVE withdraws J/K before the flip-flops' capture edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_tgt_q     <= '0;
         r_retry     <= '0;
         r_j         <= '0;
         r_k         <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_state     <= w_state_next;
         r_tgt_q     <= w_tgt_next;
         r_retry     <= w_retry_next;
         r_j         <= w_j_next;
         r_k         <= w_k_next;
         r_done      <= w_done_next;
         r_err       <= w_err_next;
         r_err_count <= w_err_count_next;
      end
   end

   assign tgt_ready = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_DRIVE) || (r_state == ST_CHECK);
   assign j_out     = r_j;
   assign k_out     = r_k;
   assign done      = r_done;
   assign err       = r_err;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver. It runs a set/reset instance (index 0) and
// a toggle instance (index 1) side by side, each with its own JK flip-flop
// model. Expected outcomes are queued at each request and popped when the
// instance reports done or err.
module tb_jk_excitation_driver;

   localparam int MR = 2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            tgt_valid;
   logic [3:0]      tgt_data;
   logic [1:0][3:0] qm;
   logic [1:0][3:0] j_o;
   logic [1:0][3:0] k_o;
   logic [1:0]      rdy;
   logic [1:0]      bsy;
   logic [1:0]      dn;
   logic [1:0]      er;
   logic [1:0][7:0] ecnt;

   logic            load_en;
   logic [3:0]      load_val;
   logic [3:0]      stuck0;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic       is_err;
      int         lat;
      logic [3:0] q;
      int         passes;
      logic [7:0] ecnt;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   int   exp_ecnt[2];

   always #5 clk = ~clk;

   jk_excitation_driver #(.WIDTH(4), .TOGGLE_MODE(0), .MAX_RETRY(MR)) dut0 (
      .clk(clk), .reset_n(reset_n), .tgt_valid(tgt_valid), .tgt_ready(rdy[0]),
      .tgt_data(tgt_data), .q_fb(qm[0]), .j_out(j_o[0]), .k_out(k_o[0]),
      .busy(bsy[0]), .done(dn[0]), .err(er[0]), .err_count(ecnt[0])
   );

   jk_excitation_driver #(.WIDTH(4), .TOGGLE_MODE(1), .MAX_RETRY(MR)) dut1 (
      .clk(clk), .reset_n(reset_n), .tgt_valid(tgt_valid), .tgt_ready(rdy[1]),
      .tgt_data(tgt_data), .q_fb(qm[1]), .j_out(j_o[1]), .k_out(k_o[1]),
      .busy(bsy[1]), .done(dn[1]), .err(er[1]), .err_count(ecnt[1])
   );

   // Characteristic equation of a JK flip-flop: Q+ = J&~Q | ~K&Q
   function automatic logic [3:0] ff_next(input logic [3:0] q, input logic [3:0] j,
                                          input logic [3:0] k);
      return (j & ~q) | (~k & q);
   endfunction

   // Returns {J,K} needed to move c to t under the given encoding
   function automatic logic [7:0] excite(input logic [3:0] c, input logic [3:0] t,
                                         input int tm);
      if (tm != 0) return {c ^ t, c ^ t};
      return {~c & t, c & ~t};
   endfunction

   // Negative-edge flip-flop models; bits set in stuck0 are held low on instance 0
   always @(negedge clk) begin
      if (load_en) begin
         qm[0] <= load_val & ~stuck0;
         qm[1] <= load_val;
      end else begin
         qm[0] <= ff_next(qm[0], j_o[0], k_o[0]) & ~stuck0;
         qm[1] <= ff_next(qm[1], j_o[1], k_o[1]);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic preload(input logic [3:0] v);
      load_val = v;
      load_en  = 1'b1;
      @(posedge clk); #2;
      load_en  = 1'b0;
   endtask

   // Present one target. With hold set, tgt_valid stays high and tgt_data is
   // scrambled while the instances are busy.
   task automatic send(input logic [3:0] t, input bit hold);
      exp_t       e;
      exp_t       got;
      logic [7:0] x;
      logic [3:0] stk;
      logic [3:0] ex_j[2];
      logic [3:0] ex_k[2];
      bit         fin[2];
      bit         prev_nz[2];
      bit         nz;
      int         passes[2];
      tgt_valid = 1'b1;
      tgt_data  = t;
      for (int d = 0; d < 2; d++) begin
         stk = (d == 0) ? stuck0 : 4'h0;
         x   = excite(qm[d], t, d);
         ex_j[d] = x[7:4];
         ex_k[d] = x[3:0];
         e.q      = t & ~stk;
         e.is_err = 1'b0;
         e.lat    = 2;
         if (x == 8'h00)            e.passes = 0;
         else if ((t & stk) == 4'h0) e.passes = 1;
         else begin
            e.passes = MR + 1;
            e.lat    = 2 * (MR + 1);
            e.is_err = 1'b1;
            if (exp_ecnt[d] < 255) exp_ecnt[d]++;
         end
         e.ecnt = 8'(exp_ecnt[d]);
         if (d == 0) sb0.push_back(e);
         else        sb1.push_back(e);
         fin[d] = 1'b0; prev_nz[d] = 1'b0; passes[d] = 0;
      end
      @(posedge clk); #2;
      if (!hold) tgt_valid = 1'b0;
      for (int n = 0; n < 30 && !(fin[0] && fin[1]); n++) begin
         if (n > 0) begin @(posedge clk); #2; end
         for (int d = 0; d < 2; d++) begin
            if (fin[d]) begin
               check_eq($sformatf("d%0d_idle_pulse", d), 32'({dn[d], er[d]}), 32'd0);
            end else begin
               if (n == 0) begin
                  check_eq($sformatf("d%0d_drive_j t=%h", d, t), 32'(j_o[d]), 32'(ex_j[d]));
                  check_eq($sformatf("d%0d_drive_k t=%h", d, t), 32'(k_o[d]), 32'(ex_k[d]));
                  check_eq($sformatf("d%0d_no_early_pulse", d), 32'({dn[d], er[d]}), 32'd0);
               end
               if (dn[d] || er[d]) begin
                  fin[d] = 1'b1;
                  check_eq($sformatf("d%0d_sb_nonempty", d),
                           32'((d == 0) ? sb0.size() : sb1.size()), 32'd1);
                  got = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                  check_eq($sformatf("d%0d_done_err t=%h", d, t), 32'({dn[d], er[d]}),
                           32'({~got.is_err, got.is_err}));
                  check_eq($sformatf("d%0d_latency", d), 32'(n), 32'(got.lat));
                  check_eq($sformatf("d%0d_q", d), 32'(qm[d]), 32'(got.q));
                  check_eq($sformatf("d%0d_err_count", d), 32'(ecnt[d]), 32'(got.ecnt));
                  check_eq($sformatf("d%0d_passes", d), 32'(passes[d]), 32'(got.passes));
                  check_eq($sformatf("d%0d_ready_back", d), 32'({rdy[d], bsy[d]}), 32'b10);
                  check_eq($sformatf("d%0d_jk_zero_at_end", d), 32'({j_o[d], k_o[d]}), 32'd0);
               end else begin
                  check_eq($sformatf("d%0d_busy n=%0d", d, n), 32'({rdy[d], bsy[d]}), 32'b01);
                  nz = (j_o[d] != 4'h0) || (k_o[d] != 4'h0);
                  check_eq($sformatf("d%0d_jk_one_cycle", d), 32'(nz && prev_nz[d]), 32'd0);
                  prev_nz[d] = nz;
                  if (nz) passes[d]++;
               end
            end
         end
         if (hold && !(fin[0] && fin[1])) tgt_data = 4'($urandom);
      end
      check_eq("d0_finished", 32'(fin[0]), 32'd1);
      check_eq("d1_finished", 32'(fin[1]), 32'd1);
   endtask

   initial begin
      logic [1:0][3:0] q_snap;
      reset_n   = 1'b0;
      tgt_valid = 1'b0;
      tgt_data  = 4'h0;
      load_en   = 1'b0;
      load_val  = 4'h0;
      stuck0    = 4'h0;
      exp_ecnt[0] = 0;
      exp_ecnt[1] = 0;
      @(posedge clk); #2;
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("d%0d_rst_jk", d), 32'({j_o[d], k_o[d]}), 32'd0);
         check_eq($sformatf("d%0d_rst_rdy_busy", d), 32'({rdy[d], bsy[d]}), 32'b10);
         check_eq($sformatf("d%0d_rst_pulses", d), 32'({dn[d], er[d]}), 32'd0);
         check_eq($sformatf("d%0d_rst_ecnt", d), 32'(ecnt[d]), 32'd0);
      end
      reset_n = 1'b1;
      @(posedge clk); #2;

      // set/reset and toggle encodings
      preload(4'b0000); send(4'b1010, 1'b0);
      preload(4'b1100); send(4'b0110, 1'b0);
      q_snap = qm;
      repeat (3) @(posedge clk);
      #2;
      check_eq("d0_q_stable", 32'(qm[0]), 32'(q_snap[0]));
      check_eq("d1_q_stable", 32'(qm[1]), 32'(q_snap[1]));

      // no-change target
      preload(4'b0101); send(4'b0101, 1'b0);

      // valid held high with data changing while busy
      preload(4'b0000);
      send(4'b0011, 1'b1);
      send(4'b1001, 1'b1);
      send(4'b0110, 1'b0);

      // stuck bit on the set/reset instance
      stuck0 = 4'b0001;
      preload(4'b0000); send(4'b0001, 1'b0);
      stuck0 = 4'b0000;

      // reset in the middle of DRIVE
      preload(4'b0000);
      tgt_valid = 1'b1; tgt_data = 4'hF;
      @(posedge clk); #2;
      tgt_valid = 1'b0;
      check_eq("d0_mid_drive_j", 32'(j_o[0]), 32'hF);
      reset_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("d%0d_arst_jk", d), 32'({j_o[d], k_o[d]}), 32'd0);
         check_eq($sformatf("d%0d_arst_rdy_busy", d), 32'({rdy[d], bsy[d]}), 32'b10);
         check_eq($sformatf("d%0d_arst_ecnt", d), 32'(ecnt[d]), 32'd0);
         check_eq($sformatf("d%0d_arst_pulses", d), 32'({dn[d], er[d]}), 32'd0);
      end
      exp_ecnt[0] = 0;
      exp_ecnt[1] = 0;
      @(posedge clk); #2;
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("d%0d_arst_q_held", d), 32'(qm[d]), 32'd0);
         check_eq($sformatf("d%0d_arst_no_pulse", d), 32'({dn[d], er[d]}), 32'd0);
      end
      reset_n = 1'b1;
      @(posedge clk); #2;
      send(4'hF, 1'b0);

      // a few arbitrary targets from whatever state the flip-flops are in
      for (int i = 0; i < 4; i++) send(4'($urandom), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
